// File: rtl/time_set_ctrl.sv
// Front-panel HH:MM entry controller for the alarm clock core: debounced buttons,
// per-digit editing with range-checked wrap, and a stretched load strobe on commit.
`timescale 1ns/1ps

module time_set_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int LD_HOLD    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       BTN_time,
    input  logic       BTN_alarm,
    input  logic       BTN_inc,
    input  logic       BTN_enter,
    input  logic       BTN_mode,
    output logic [1:0] H_set1,
    output logic [3:0] H_set0,
    output logic [3:0] M_set1,
    output logic [3:0] M_set0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [3:0] EDIT_digit,
    output logic       Busy
);

    localparam int B_TIME  = 0;
    localparam int B_ALARM = 1;
    localparam int B_INC   = 2;
    localparam int B_ENTER = 3;
    localparam int B_MODE  = 4;

    localparam logic [7:0]    DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam int            CW        = $clog2(LD_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(LD_HOLD);

    typedef enum logic [2:0] {IDLE, SET_H1, SET_H0, SET_M1, SET_M0, LOAD} state_t;

    state_t        state, state_nxt;
    logic [4:0]    raw, press;
    logic          start_edit, start_alarm, inc_en, commit;
    logic          target_alarm;
    logic [CW-1:0] ld_cnt;
    logic [1:0]    w_h1;
    logic [3:0]    w_h0, w_m1, w_m0;
    logic [1:0]    h1_inc;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] top);
        return (v >= top) ? 4'd0 : v + 4'd1;
    endfunction

    assign raw = {BTN_mode, BTN_enter, BTN_inc, BTN_alarm, BTN_time};

    // Button front end: 2-FF synchronizer, debounce counter, rising-edge press pulse
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic       sync_a, sync_b, level, level_d, pulse;
        logic [7:0] cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_a  <= 1'b0;
                sync_b  <= 1'b0;
                level   <= 1'b0;
                level_d <= 1'b0;
                pulse   <= 1'b0;
                cnt     <= 8'd0;
            end else begin
                sync_a  <= raw[i];
                sync_b  <= sync_a;
                level_d <= level;
                pulse   <= level & ~level_d;
                if (sync_b != level) begin
                    if (cnt == DEB_LAST) begin
                        level <= sync_b;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end else begin
                    cnt <= 8'd0;
                end
            end
        end

        assign press[i] = pulse;
    end

    // Next-state and command decode; mode beats enter beats inc inside an edit
    always_comb begin
        state_nxt   = state;
        start_edit  = 1'b0;
        start_alarm = 1'b0;
        inc_en      = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (press[B_TIME]) begin
                    state_nxt  = SET_H1;
                    start_edit = 1'b1;
                end else if (press[B_ALARM]) begin
                    state_nxt   = SET_H1;
                    start_edit  = 1'b1;
                    start_alarm = 1'b1;
                end
            end
            SET_H1, SET_H0, SET_M1, SET_M0: begin
                if (press[B_MODE]) begin
                    state_nxt = IDLE;
                end else if (press[B_ENTER]) begin
                    case (state)
                        SET_H1:  state_nxt = SET_H0;
                        SET_H0:  state_nxt = SET_M1;
                        SET_M1:  state_nxt = SET_M0;
                        default: begin
                            state_nxt = LOAD;
                            commit    = 1'b1;
                        end
                    endcase
                end else if (press[B_INC]) begin
                    inc_en = 1'b1;
                end
            end
            LOAD: begin
                if (ld_cnt == HOLD_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Committed set, load target and strobe counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            H_set1       <= 2'd0;
            H_set0       <= 4'd0;
            M_set1       <= 4'd0;
            M_set0       <= 4'd0;
            target_alarm <= 1'b0;
            ld_cnt       <= '0;
        end else begin
            if (start_edit) target_alarm <= start_alarm;
            if (commit) begin
                H_set1 <= w_h1;
                H_set0 <= w_h0;
                M_set1 <= w_m1;
                M_set0 <= w_m0;
                ld_cnt <= '0;
            end else if (state == LOAD && ld_cnt != HOLD_LAST) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end

    assign h1_inc = 2'(wrap_inc({2'b00, w_h1}, 4'd2));

    // Working set: loaded from the committed set on entry, no reset needed
    always_ff @(posedge clk) begin
        if (start_edit) begin
            w_h1 <= H_set1;
            w_h0 <= H_set0;
            w_m1 <= M_set1;
            w_m0 <= M_set0;
        end else if (inc_en) begin
            case (state)
                SET_H1: begin
                    w_h1 <= h1_inc;
                    // Moving into the 20s must not leave an illegal 24..29
                    if (h1_inc == 2'd2 && w_h0 > 4'd3) w_h0 <= 4'd0;
                end
                SET_H0:  w_h0 <= wrap_inc(w_h0, (w_h1 == 2'd2) ? 4'd3 : 4'd9);
                SET_M1:  w_m1 <= wrap_inc(w_m1, 4'd5);
                SET_M0:  w_m0 <= wrap_inc(w_m0, 4'd9);
                default: ;
            endcase
        end
    end

    // The strobe covers the first LD_HOLD cycles of LOAD; Busy lingers one more
    assign LD_time  = (state == LOAD) && (ld_cnt != HOLD_LAST) && !target_alarm;
    assign LD_alarm = (state == LOAD) && (ld_cnt != HOLD_LAST) &&  target_alarm;
    assign Busy     = (state != IDLE);

    always_comb begin
        EDIT_digit = 4'b0000;
        case (state)
            SET_H1:  EDIT_digit = 4'b1000;
            SET_H0:  EDIT_digit = 4'b0100;
            SET_M1:  EDIT_digit = 4'b0010;
            SET_M0:  EDIT_digit = 4'b0001;
            default: EDIT_digit = 4'b0000;
        endcase
    end

endmodule
